window_conv_op: RTL and testbench
=================================

# window_conv_op

Parametrised successor to the fixed 3×3 centre-pass operation stage. It receives a tagged OPE_WIDTH×OPE_WIDTH pixel window each cycle and applies a runtime-programmable signed convolution kernel. The result is shifted, optionally made absolute (the absolute-value unit is now instantiated), and saturated. It emits one tagged pixel per cycle after a fixed 3-cycle pipeline. The block sits between the window line-buffer and the output serialiser. Kernel and control changes are double-buffered, so they only take effect on a frame boundary.

## Interface
- TAG_WIDTH, 2, tag field width
- INVALID_TAG / DATA_TAG0 / DATA_TAG1 / DATA_END_TAG, 0/1/2/3, tag codes
- OPE_WIDTH, 3, window edge (odd, ≥3); N = OPE_WIDTH²
- PIX_WIDTH, 8, unsigned pixel width
- DATA_WIDTH, PIX_WIDTH+TAG_WIDTH, beat width {tag, pixel}
- COEF_WIDTH, 8, signed coefficient width (≥5)
- ADDR_WIDTH, clog2(N+1), config address width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- reflesh  in  1  synchronous pipeline flush; keeps configuration
- data_bus  in  DATA_WIDTH*N  window; element (y,x) at bits [((y*OPE_WIDTH+x)*DATA_WIDTH) +: DATA_WIDTH]
- cfg_we  in  1  write shadow register
- cfg_addr  in  ADDR_WIDTH  0..N-1 = coef k[y][x] (index y*OPE_WIDTH+x); N = control
- cfg_data  in  COEF_WIDTH  coefficient, or control {bit4 abs_en, bits3:0 shift}
- cfg_commit  in  1  request shadow→active copy
- cfg_pending  out  1  commit requested, not yet applied
- out  out  DATA_WIDTH  {tag, pixel}

## Operation
- The input tag is the centre element's tag. DATA_TAG0 and DATA_TAG1 are data beats. INVALID_TAG and DATA_END_TAG are non-data beats.
- Data beat computation:
  - sum = Σ k[y][x]·p[y][x], with pixels zero-extended to signed.
  - Sum width is PIX_WIDTH+COEF_WIDTH+1+clog2(N); there is no intermediate overflow.
  - r = sum >>> shift (arithmetic shift).
  - If abs_en, r = |r|; otherwise negative r becomes 0.
  - r saturates to 2^PIX_WIDTH−1.
- Non-data beat: output pixel is all-ones, and the tag passes through unchanged.
- The tag travels in lock-step with its pixel through all stages.
- Reset values:
  - Active and shadow kernel are identity: centre 1, others 0. shift=0, abs_en=0.
  - cfg_pending=0. All pipeline tags = INVALID_TAG, pixels 0, so out=0.
- Shadow writes and invalid addresses:
  - cfg_we writes the shadow copy only.
  - An address > N is ignored.
- Commit rules:
  - cfg_commit sets cfg_pending.
  - The copy shadow→active happens at the edge of any cycle where cfg_pending (or cfg_commit) is set and the input tag is DATA_END_TAG or INVALID_TAG. cfg_pending then clears.
  - A cfg_we in the same cycle as the copy is forwarded into the copy.
  - Active config never changes on a data-beat cycle, so a frame is never processed with mixed kernels.
- reflesh:
  - Clears all pipeline stages next edge: out=0 for 3 cycles unless new beats arrive.
  - Does not touch shadow, active config or cfg_pending.
- rst has priority over reflesh and cfg_*.

## Timing
- Stage 1: register the N products and the tag.
- Stage 2: register the adder-tree sum and the tag.
- Stage 3: shift, abs/clamp, saturate; register out.
- Latency: input at edge t appears on out after edge t+3. Throughput is 1 beat/cycle; there is no backpressure.
- Config is sampled at stage 1. A beat entering on the cycle of a commit copy uses the old config; that beat is non-data by rule.
- reflesh or rst mid-frame drops in-flight beats. It does not cause partial or corrupted output.
- cfg_pending rises the edge after cfg_commit and falls on the copy edge. Both can occur on the same edge, in which case cfg_pending stays 0.

## Structure
- Package window_conv_pkg holds:
  - tag code constants;
  - control bit positions (ABS_BIT=4, SHIFT_LSB=0, SHIFT_W=4);
  - a sum-width function sum_width(PIX,COEF,N).
- Sub-module abs_clamp (parametrised in/out width, abs_en input, combinational) implements the stage-3 abs/clamp/saturate.
- The adder tree is a generate loop in the top module.

## Test plan
- After reset, centre 0x5A with DATA_TAG1 (others random) → out {DATA_TAG1, 0x5A} after 3 cycles; INVALID_TAG beat → {INVALID_TAG, 0xFF}.
- Box sum: all k=1, shift=3, commit during idle, all pixels 0x10 → 144>>3 = 0x12.
- Sobel-x [-1 0 1; -2 0 2; -1 0 1]:
  - left column 0, right 0xFF → 1020 → saturates to 0xFF;
  - mirrored window, abs_en=0 → 0x00;
  - mirrored window, abs_en=1 → 0xFF.
- Laplacian: centre k=4, 4-neighbours k=−1, corners 0; centre 0x20, neighbours 0x10 → 0x40.
- Deferred commit:
  - Write a new kernel and pulse cfg_commit mid-frame. All remaining data beats still use the old kernel, and cfg_pending=1 until DATA_END_TAG.
  - The first beat of the next frame uses the new kernel.
- Flush: assert reflesh with 3 beats in flight → out=0 for the next 3 cycles; config and cfg_pending unchanged.

Source files
------------

// File: rtl/window_conv_op_pkg.sv
`default_nettype none
// ============================================================================
// Module      : window_conv_pkg
// Description : Shared constants for the window convolution stage. It holds
//               the tag codes, the control-word bit positions and the helper
//               that sizes the accumulator.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package window_conv_pkg;

    localparam int TAG_WIDTH = 2;

    localparam logic [TAG_WIDTH-1:0] INVALID_TAG  = 2'd0;
    localparam logic [TAG_WIDTH-1:0] DATA_TAG0    = 2'd1;
    localparam logic [TAG_WIDTH-1:0] DATA_TAG1    = 2'd2;
    localparam logic [TAG_WIDTH-1:0] DATA_END_TAG = 2'd3;

    // Control word layout, written at config address N
    localparam int ABS_BIT   = 4;
    localparam int SHIFT_LSB = 0;
    localparam int SHIFT_W   = 4;

    // Width that holds the sum of n products of an unsigned pixel and a
    // signed coefficient without overflow.
    function automatic int sum_width(input int pix, input int coef, input int n);
        return pix + coef + 1 + $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/window_conv_op_if.sv
`default_nettype none
// ============================================================================
// Module      : window_conv_op_if
// Description : Bundles the window input, the configuration port and the
//               tagged pixel output of window_conv_op.
//   reflesh     : pipeline flush
//   data_bus    : N tagged pixels, element (y,x) at index y*OPE_WIDTH+x
//   cfg_we/addr/data/commit : shadow write and commit request
//   cfg_pending : a commit is waiting for a frame boundary
//   out         : {tag, pixel}
// Revision    : 1.0 - initial parametrised release
// ============================================================================
interface window_conv_op_if
    import window_conv_pkg::*;
#(
    parameter int OPE_WIDTH  = 3,
    parameter int PIX_WIDTH  = 8,
    parameter int COEF_WIDTH = 8
);
    localparam int N          = OPE_WIDTH * OPE_WIDTH;
    localparam int DATA_WIDTH = PIX_WIDTH + TAG_WIDTH;
    localparam int ADDR_WIDTH = $clog2(N + 1);

    logic                    reflesh;
    logic [DATA_WIDTH*N-1:0] data_bus;
    logic                    cfg_we;
    logic [ADDR_WIDTH-1:0]   cfg_addr;
    logic [COEF_WIDTH-1:0]   cfg_data;
    logic                    cfg_commit;
    logic                    cfg_pending;
    logic [DATA_WIDTH-1:0]   out;

    modport master (
        output reflesh, data_bus, cfg_we, cfg_addr, cfg_data, cfg_commit,
        input  cfg_pending, out
    );

    modport slave (
        input  reflesh, data_bus, cfg_we, cfg_addr, cfg_data, cfg_commit,
        output cfg_pending, out
    );

endinterface
`default_nettype wire

// File: rtl/window_conv_op_abs_clamp.sv
`default_nettype none
// ============================================================================
// Module      : abs_clamp
// Description : Combinational output conditioning. A negative input is either
//               mirrored (i_abs_en) or forced to zero, and the result is then
//               saturated to the OUT_W-bit unsigned range.
//   i_din    : signed value, IN_W bits (IN_W > OUT_W)
//   i_abs_en : take the magnitude instead of clamping negatives
//   o_dout   : unsigned saturated result
// Revision    : 1.0 - initial release
// ============================================================================
module abs_clamp #(
    parameter int IN_W  = 21,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0] i_din,
    input  logic                   i_abs_en,
    output logic [OUT_W-1:0]       o_dout
);
    // One extra bit so that negating the most negative input cannot wrap
    logic signed [IN_W:0] w_ext;
    logic signed [IN_W:0] w_mag;

    always_comb begin
        w_ext = {i_din[IN_W-1], i_din};
        w_mag = w_ext;
        if (i_din[IN_W-1]) begin
            w_mag = i_abs_en ? -w_ext : '0;
        end
        // w_mag is non-negative here, so any high bit means overflow
        o_dout = (|w_mag[IN_W:OUT_W]) ? '1 : w_mag[OUT_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/window_conv_op.sv
`default_nettype none
// ============================================================================
// Module      : window_conv_op
// Description : Three-stage signed convolution over a tagged window. Stage 1
//               registers the products, stage 2 registers the sum and stage 3
//               applies shift, abs/clamp and saturation. The kernel and the
//               control word are double-buffered and swap only on non-data
//               beats.
//   clk, rst : clock and synchronous active-high reset
//   conv_if  : slave side of window_conv_op_if (window, config, out)
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module window_conv_op
    import window_conv_pkg::*;
#(
    parameter int OPE_WIDTH  = 3,
    parameter int PIX_WIDTH  = 8,
    parameter int COEF_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    window_conv_op_if.slave conv_if
);
    localparam int c_N      = OPE_WIDTH * OPE_WIDTH;
    localparam int c_CTR    = (c_N - 1) / 2;
    localparam int c_DW     = PIX_WIDTH + TAG_WIDTH;
    localparam int c_AW     = $clog2(c_N + 1);
    localparam int c_PROD_W = PIX_WIDTH + COEF_WIDTH + 1;
    localparam int c_SUM_W  = sum_width(PIX_WIDTH, COEF_WIDTH, c_N);

    // ---------------- input decode ----------------
    logic [PIX_WIDTH-1:0] w_pix [c_N];
    logic [TAG_WIDTH-1:0] w_tag_in;
    logic                 w_nondata_in;
    logic                 w_unused_tags;

    always_comb begin
        w_unused_tags = 1'b0;
        for (int i = 0; i < c_N; i++) begin
            w_pix[i]      = conv_if.data_bus[i*c_DW +: PIX_WIDTH];
            // Only the centre tag steers the beat; the others are ignored
            w_unused_tags = w_unused_tags ^ (^conv_if.data_bus[i*c_DW+PIX_WIDTH +: TAG_WIDTH]);
        end
    end

    assign w_tag_in     = conv_if.data_bus[c_CTR*c_DW+PIX_WIDTH +: TAG_WIDTH];
    assign w_nondata_in = (w_tag_in == INVALID_TAG) || (w_tag_in == DATA_END_TAG);

    // ---------------- configuration ----------------
    logic signed [COEF_WIDTH-1:0] r_sh_k  [c_N];
    logic signed [COEF_WIDTH-1:0] r_act_k [c_N];
    logic signed [COEF_WIDTH-1:0] w_nx_k  [c_N];
    logic [SHIFT_W-1:0]           r_sh_shift, r_act_shift, w_nx_shift;
    logic                         r_sh_abs, r_act_abs, w_nx_abs;
    logic                         r_pending;
    logic                         w_copy;

    // Next shadow contents, including this cycle's write, so a write that
    // coincides with the copy lands in the active set too.
    always_comb begin
        w_nx_shift = r_sh_shift;
        w_nx_abs   = r_sh_abs;
        for (int i = 0; i < c_N; i++) begin
            w_nx_k[i] = r_sh_k[i];
            if (conv_if.cfg_we && (conv_if.cfg_addr == c_AW'(i))) begin
                w_nx_k[i] = conv_if.cfg_data;
            end
        end
        if (conv_if.cfg_we && (conv_if.cfg_addr == c_AW'(c_N))) begin
            w_nx_shift = conv_if.cfg_data[SHIFT_LSB +: SHIFT_W];
            w_nx_abs   = conv_if.cfg_data[ABS_BIT];
        end
    end

    assign w_copy = (r_pending || conv_if.cfg_commit) && w_nondata_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_N; i++) begin
                r_sh_k[i]  <= (i == c_CTR) ? COEF_WIDTH'(1) : '0;
                r_act_k[i] <= (i == c_CTR) ? COEF_WIDTH'(1) : '0;
            end
            r_sh_shift  <= '0;
            r_act_shift <= '0;
            r_sh_abs    <= 1'b0;
            r_act_abs   <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            r_sh_k     <= w_nx_k;
            r_sh_shift <= w_nx_shift;
            r_sh_abs   <= w_nx_abs;
            if (w_copy) begin
                r_act_k     <= w_nx_k;
                r_act_shift <= w_nx_shift;
                r_act_abs   <= w_nx_abs;
            end
            r_pending <= w_copy ? 1'b0 : (conv_if.cfg_commit ? 1'b1 : r_pending);
        end
    end

    assign conv_if.cfg_pending = r_pending;

    // ---------------- datapath ----------------
    logic signed [c_PROD_W-1:0] w_prod [c_N];
    logic signed [c_PROD_W-1:0] r_prod [c_N];
    logic [TAG_WIDTH-1:0]       r_tag1, r_tag2;
    logic                       r_vld1, r_vld2;
    logic [SHIFT_W-1:0]         r_shift1, r_shift2;
    logic                       r_abs1, r_abs2;
    logic signed [c_SUM_W-1:0]  r_sum;
    logic signed [c_SUM_W-1:0]  w_sum;
    logic signed [c_SUM_W-1:0]  w_shifted;
    logic [PIX_WIDTH-1:0]       w_clamped;
    logic [PIX_WIDTH-1:0]       w_pix_out;
    logic [c_DW-1:0]            r_out;

    always_comb begin
        for (int i = 0; i < c_N; i++) begin
            w_prod[i] = $signed({{(c_PROD_W-PIX_WIDTH){1'b0}}, w_pix[i]}) *
                        $signed({{(c_PROD_W-COEF_WIDTH){r_act_k[i][COEF_WIDTH-1]}}, r_act_k[i]});
        end
    end

    // Running sum of sign-extended products, one adder per window element
    for (genvar gi = 0; gi < c_N; gi++) begin : g_tree
        logic signed [c_SUM_W-1:0] w_part;
        if (gi == 0) begin : g_first
            assign w_part = $signed({{(c_SUM_W-c_PROD_W){r_prod[gi][c_PROD_W-1]}}, r_prod[gi]});
        end else begin : g_next
            assign w_part = g_tree[gi-1].w_part +
                            $signed({{(c_SUM_W-c_PROD_W){r_prod[gi][c_PROD_W-1]}}, r_prod[gi]});
        end
    end

    assign w_sum     = g_tree[c_N-1].w_part;
    assign w_shifted = r_sum >>> r_shift2;

    abs_clamp #(
        .IN_W  (c_SUM_W),
        .OUT_W (PIX_WIDTH)
    ) u_abs_clamp (
        .i_din    (w_shifted),
        .i_abs_en (r_abs2),
        .o_dout   (w_clamped)
    );

    assign w_pix_out = ((r_tag2 == DATA_TAG0) || (r_tag2 == DATA_TAG1)) ? w_clamped : '1;

    // r_vld* mark real beats, so the bubbles left by reset/flush emit 0
    // instead of looking like INVALID_TAG beats.
    always_ff @(posedge clk) begin
        if (rst || conv_if.reflesh) begin
            for (int i = 0; i < c_N; i++) begin
                r_prod[i] <= '0;
            end
            r_tag1   <= INVALID_TAG;
            r_tag2   <= INVALID_TAG;
            r_vld1   <= 1'b0;
            r_vld2   <= 1'b0;
            r_shift1 <= '0;
            r_shift2 <= '0;
            r_abs1   <= 1'b0;
            r_abs2   <= 1'b0;
            r_sum    <= '0;
            r_out    <= '0;
        end else begin
            r_prod   <= w_prod;
            r_tag1   <= w_tag_in;
            r_vld1   <= 1'b1;
            r_shift1 <= r_act_shift;
            r_abs1   <= r_act_abs;
            r_sum    <= w_sum;
            r_tag2   <= r_tag1;
            r_vld2   <= r_vld1;
            r_shift2 <= r_shift1;
            r_abs2   <= r_abs1;
            r_out    <= r_vld2 ? {r_tag2, w_pix_out} : '0;
        end
    end

    assign conv_if.out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_window_conv_op.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_conv_op
// Description : Directed bench for window_conv_op with a behavioural model
//               of the whole block, checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_conv_op;

    localparam int c_N   = 9;
    localparam int c_MAX = 4096;

    logic clk = 1'b0;
    logic rst;

    window_conv_op_if #(.OPE_WIDTH(3), .PIX_WIDTH(8), .COEF_WIDTH(8)) conv_if ();

    window_conv_op #(.OPE_WIDTH(3), .PIX_WIDTH(8), .COEF_WIDTH(8)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .conv_if (conv_if.slave)
    );

    always #5 clk = ~clk;

    // stimulus state
    int         w_pix [c_N];
    logic [1:0] w_tag;
    logic       t_rst, t_fl, t_we, t_commit;
    logic [3:0] t_addr;
    logic [7:0] t_data;

    // model state
    int   m_sh_k [c_N];
    int   m_act_k [c_N];
    int   m_sh_shift, m_act_shift;
    bit   m_sh_abs, m_act_abs, m_pend;
    logic [9:0] exp_out [c_MAX];
    logic       exp_pend [c_MAX];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic logic [9:0] model_out();
        int s, r;
        if (w_tag == 2'd1 || w_tag == 2'd2) begin
            s = 0;
            for (int i = 0; i < c_N; i++) s += m_act_k[i] * w_pix[i];
            r = s >>> m_act_shift;
            if (r < 0) r = m_act_abs ? -r : 0;
            if (r > 255) r = 255;
            return {w_tag, 8'(r)};
        end
        return {w_tag, 8'hFF};
    endfunction

    task automatic chk(input string name, input logic [9:0] got, input logic [9:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Drive one cycle, advance the model for that edge, return #1 after it.
    task automatic tick();
        int e;
        bit nd, cp;
        logic [89:0] bus;
        e = cyc + 1;
        for (int i = 0; i < c_N; i++) begin
            bus[i*10 +: 8]   = 8'(w_pix[i]);
            bus[i*10+8 +: 2] = w_tag;
        end
        conv_if.data_bus   = bus;
        rst                = t_rst;
        conv_if.reflesh    = t_fl;
        conv_if.cfg_we     = t_we;
        conv_if.cfg_addr   = t_addr;
        conv_if.cfg_data   = t_data;
        conv_if.cfg_commit = t_commit;
        if (t_rst) begin
            for (int k = 0; k < 3; k++) exp_out[e+k] = '0;
            for (int i = 0; i < c_N; i++) begin
                m_sh_k[i]  = (i == 4) ? 1 : 0;
                m_act_k[i] = (i == 4) ? 1 : 0;
            end
            m_sh_shift = 0; m_act_shift = 0;
            m_sh_abs = 0; m_act_abs = 0; m_pend = 0;
        end else begin
            if (t_fl) for (int k = 0; k < 3; k++) exp_out[e+k] = '0;
            else exp_out[e+2] = model_out();
            nd = (w_tag == 2'd0) || (w_tag == 2'd3);
            cp = (m_pend || t_commit) && nd;
            if (t_we) begin
                if (t_addr < 9) m_sh_k[t_addr] = int'($signed(t_data));
                else if (t_addr == 9) begin
                    m_sh_shift = int'(t_data[3:0]);
                    m_sh_abs   = t_data[4];
                end
            end
            if (cp) begin
                m_act_k = m_sh_k;
                m_act_shift = m_sh_shift;
                m_act_abs = m_sh_abs;
            end
            m_pend = cp ? 1'b0 : (t_commit ? 1'b1 : m_pend);
        end
        exp_pend[e] = m_pend;
        @(posedge clk);
        cyc = e;
        #1;
    endtask

    task automatic cfg_write(input int addr, input int data);
        t_we = 1'b1; t_addr = 4'(addr); t_data = 8'(data);
        tick();
        t_we = 1'b0;
    endtask

    task automatic load_kernel(input int k [c_N], input int ctrl);
        for (int i = 0; i < c_N; i++) cfg_write(i, k[i]);
        cfg_write(9, ctrl);
    endtask

    task automatic commit();
        t_commit = 1'b1;
        tick();
        t_commit = 1'b0;
    endtask

    // Present the current window for one beat, then two idle beats, and
    // check the beat's result.
    task automatic run_beat(input string name, input logic [9:0] want);
        logic [1:0] keep;
        keep = w_tag;
        tick();
        w_tag = 2'd0;
        tick();
        tick();
        chk(name, conv_if.out, want);
        w_tag = keep;
    endtask

    task automatic set_all(input int p);
        for (int i = 0; i < c_N; i++) w_pix[i] = p;
    endtask

    task automatic set_cols(input int left, input int mid, input int right);
        for (int i = 0; i < c_N; i++) w_pix[i] = (i % 3 == 0) ? left : ((i % 3 == 2) ? right : mid);
    endtask

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("model_out", conv_if.out, exp_out[cyc]);
            chk("model_pending", {9'd0, conv_if.cfg_pending}, {9'd0, exp_pend[cyc]});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k_box [c_N]   = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        int k_sobel [c_N] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
        int k_lap [c_N]   = '{0, -1, 0, -1, 4, -1, 0, -1, 0};

        for (int i = 0; i < c_MAX; i++) begin
            exp_out[i]  = '0;
            exp_pend[i] = 1'b0;
        end
        t_rst = 1'b1; t_fl = 1'b0; t_we = 1'b0; t_commit = 1'b0;
        t_addr = '0; t_data = '0; w_tag = 2'd0;
        set_all(0);

        repeat (3) tick();
        chk("reset_out", conv_if.out, 10'h000);
        chk("reset_pending", {9'd0, conv_if.cfg_pending}, 10'h000);
        t_rst = 1'b0;

        // identity kernel after reset
        for (int i = 0; i < c_N; i++) w_pix[i] = $urandom_range(0, 255);
        w_pix[4] = 8'h5A;
        w_tag = 2'd2;
        tick();
        w_tag = 2'd0;
        for (int i = 0; i < c_N; i++) w_pix[i] = $urandom_range(0, 255);
        tick();
        tick();
        chk("identity_5a", conv_if.out, 10'h25A);
        tick();
        chk("invalid_ff", conv_if.out, 10'h0FF);

        // box sum, committed while idle
        load_kernel(k_box, 8'h03);
        commit();
        chk("idle_commit_pending", {9'd0, conv_if.cfg_pending}, 10'h000);
        set_all(8'h10); w_tag = 2'd1;
        run_beat("box_sum", 10'h112);

        // Sobel-x, plus an out-of-range address that must be ignored
        w_tag = 2'd0;
        load_kernel(k_sobel, 8'h00);
        cfg_write(13, 8'h7F);
        commit();
        w_tag = 2'd1;
        set_cols(0, 8'h80, 8'hFF);
        run_beat("sobel_sat", 10'h1FF);
        set_cols(8'hFF, 8'h80, 0);
        run_beat("sobel_neg_clamp", 10'h100);
        // control write forwarded into a same-cycle commit
        w_tag = 2'd0;
        t_we = 1'b1; t_addr = 4'd9; t_data = 8'h10; t_commit = 1'b1;
        tick();
        t_we = 1'b0; t_commit = 1'b0;
        w_tag = 2'd1;
        run_beat("sobel_abs", 10'h1FF);

        // Laplacian
        w_tag = 2'd0;
        load_kernel(k_lap, 8'h00);
        commit();
        set_all(8'h10); w_pix[4] = 8'h20; w_tag = 2'd2;
        run_beat("laplacian", 10'h240);

        // deferred commit: new kernel requested mid-frame
        w_tag = 2'd1;
        tick();
        tick();
        load_kernel(k_box, 8'h03);
        commit();
        chk("deferred_pending", {9'd0, conv_if.cfg_pending}, 10'h001);
        tick();
        tick();
        chk("deferred_old_kernel", conv_if.out, 10'h140);
        chk("deferred_pending_hold", {9'd0, conv_if.cfg_pending}, 10'h001);
        w_tag = 2'd3;
        tick();
        chk("end_tag_clears", {9'd0, conv_if.cfg_pending}, 10'h000);
        w_tag = 2'd1;
        run_beat("new_frame_kernel", 10'h114);

        // flush with beats in flight and a commit outstanding
        w_tag = 2'd1;
        commit();
        tick();
        tick();
        t_fl = 1'b1;
        tick();
        t_fl = 1'b0;
        chk("flush_0", conv_if.out, 10'h000);
        tick();
        chk("flush_1", conv_if.out, 10'h000);
        tick();
        chk("flush_2", conv_if.out, 10'h000);
        chk("flush_pending", {9'd0, conv_if.cfg_pending}, 10'h001);
        tick();
        chk("post_flush_kernel", conv_if.out, 10'h114);
        w_tag = 2'd3;
        tick();
        chk("flush_end_clears", {9'd0, conv_if.cfg_pending}, 10'h000);
        w_tag = 2'd0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
